// File: rtl/spi_reg_pkg.sv
// Shared types and constants for the SPI register transaction controller.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
//
// Contents: FSM state enum, command-byte layout, default widths and status byte.
package spi_reg_pkg;

    localparam int             SPI_DATA_W      = 8;
    localparam int             SPI_ADDR_W      = 7;
    localparam int             CMD_RW_BIT      = 7;      // 1 = read, 0 = write
    localparam logic [7:0]     SPI_STATUS_BYTE = 8'hA5;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_CMD      = 3'd1,
        ST_WR       = 3'd2,
        ST_RD_ISSUE = 3'd3,
        ST_RD_CAP   = 3'd4,
        ST_RD       = 3'd5
    } state_e;

endpackage

// File: rtl/spi_reg_ctrl.sv
// Byte-stream parser behind an SPI slave: command/address/data to a register-bank port.
// Latency: write strobe 1 cycle after the data byte; read cmd at T -> rd_en T+1 -> tx_data T+3.
// Backpressure: none; bytes arriving while a read fetch is in flight are dropped and flag proto_err.
//
// Ports:
//   clk, rst                    system clock, asynchronous active-high reset
//   cs_active                   frame open (synchronised chip select)
//   rx_valid, rx_data           received byte strobe and value
//   tx_data                     byte loaded by the SPI slave at the next byte boundary
//   reg_addr, reg_wr_en,
//   reg_wdata, reg_rd_en,
//   reg_rdata                   register-bank port, read data valid the cycle after reg_rd_en
//   txn_done                    1-cycle pulse when a frame carrying a command closes
//   proto_err                   sticky overrun flag, cleared only by rst
// Build option: define SPI_REG_AUTOINC_EN to advance reg_addr after every data byte;
// otherwise the address stays at the command address for the whole frame.
module spi_reg_ctrl
    import spi_reg_pkg::*;
#(
    parameter int                DATA_W      = SPI_DATA_W,
    parameter int                ADDR_W      = SPI_ADDR_W,
    parameter logic [DATA_W-1:0] STATUS_BYTE = SPI_STATUS_BYTE
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cs_active,
    input  logic              rx_valid,
    input  logic [DATA_W-1:0] rx_data,
    output logic [DATA_W-1:0] tx_data,
    output logic [ADDR_W-1:0] reg_addr,
    output logic              reg_wr_en,
    output logic [DATA_W-1:0] reg_wdata,
    output logic              reg_rd_en,
    input  logic [DATA_W-1:0] reg_rdata,
    output logic              txn_done,
    output logic              proto_err
);

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   tx_q, tx_d;
    logic                wr_en_q, wr_en_d;
    logic                done_q, done_d;
    logic                err_q, err_d;

    logic                rx_acc;    // byte accepted for processing
    logic                cs_drop;   // frame closing this cycle

    // A byte that coincides with chip-select falling is still processed, so
    // acceptance only depends on being inside a frame (any non-IDLE state).
    assign rx_acc  = rx_valid && (state_q != ST_IDLE);
    assign cs_drop = !cs_active && (state_q != ST_IDLE);

    // ---------------------------------------------------------------- state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------------------------------------------------------- next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (cs_active) state_d = ST_CMD;
            end
            ST_CMD: begin
                if (rx_valid) state_d = rx_data[CMD_RW_BIT] ? ST_RD_ISSUE : ST_WR;
            end
            ST_WR: begin
                state_d = ST_WR;
            end
            ST_RD_ISSUE: begin
                state_d = ST_RD_CAP;
            end
            ST_RD_CAP: begin
                state_d = ST_RD;
            end
            ST_RD: begin
                // Each dummy byte triggers the prefetch of the next read byte.
                if (rx_valid) state_d = ST_RD_ISSUE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (cs_drop) state_d = ST_IDLE;
    end

    // ---------------------------------------------------------------- output logic
    // The read strobe is tied to the state so a reset removes it in the same cycle;
    // if the frame closes during RD_ISSUE the strobe still finishes its one cycle.
    always_comb begin
        reg_rd_en = (state_q == ST_RD_ISSUE);
    end

    // ---------------------------------------------------------------- datapath next-state
    always_comb begin
        addr_d  = addr_q;
        wdata_d = wdata_q;
        tx_d    = tx_q;
        wr_en_d = 1'b0;
        err_d   = err_q;
        done_d  = 1'b0;

        // Address: loaded from the command byte, optionally advanced per data byte.
        if (state_q == ST_CMD && rx_acc) begin
            addr_d = rx_data[ADDR_W-1:0];
        end
`ifdef SPI_REG_AUTOINC_EN
        // Writes advance once the strobe has gone out at the current address;
        // reads advance on the dummy byte so the prefetch targets the next register.
        // Natural overflow gives the mod 2**ADDR_W wrap.
        else if (wr_en_q) begin
            addr_d = addr_q + ADDR_W'(1);
        end else if (state_q == ST_RD && rx_acc) begin
            addr_d = addr_q + ADDR_W'(1);
        end
`else
        // Fixed-address mode: every data byte of the frame targets the command address.
        else begin
            addr_d = addr_q;
        end
`endif

        // Write data and strobe: strobe is registered so it lands one cycle after the byte.
        if (state_q == ST_WR && rx_acc) begin
            wdata_d = rx_data;
            wr_en_d = 1'b1;
        end

        // Transmit byte. A closing frame discards any pending capture.
        if (cs_drop) begin
            tx_d = STATUS_BYTE;
        end else if (state_q == ST_IDLE || state_q == ST_CMD) begin
            tx_d = STATUS_BYTE;
        end else if (state_q == ST_RD_CAP) begin
            tx_d = reg_rdata;
        end

        // Overrun: a byte arrived before the previous read fetch finished.
        if ((state_q == ST_RD_ISSUE || state_q == ST_RD_CAP) && rx_acc) begin
            err_d = 1'b1;
        end

        // A frame closing from CMD has not carried a command unless the command
        // byte arrives together with the chip-select fall.
        if (cs_drop && (state_q != ST_CMD || rx_valid)) begin
            done_d = 1'b1;
        end
    end

    // ---------------------------------------------------------------- datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q  <= '0;
            wdata_q <= '0;
            tx_q    <= STATUS_BYTE;
            wr_en_q <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            tx_q    <= tx_d;
            wr_en_q <= wr_en_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign tx_data   = tx_q;
    assign reg_addr  = addr_q;
    assign reg_wr_en = wr_en_q;
    assign reg_wdata = wdata_q;
    assign txn_done  = done_q;
    assign proto_err = err_q;

endmodule
